race_ctrl: RTL and testbench

Race sequencer for the racing game. It runs the start countdown, gates car motion, and counts laps, crediting a lap only when the lap line is crossed with all checkpoints passed. It also times the race and each lap, and declares the race finished after LAPS valid laps. It sits between the checkpoint tracker outputs (lap_finished, checkpoints_passed) and the car-motion and HUD/draw logic.

---
 rtl/race_pkg.sv | 22 ++
 rtl/race_tick_gen.sv | 38 +++
 rtl/race_ctrl.sv | 179 +++++++++++++++++
 tb/tb_race_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// race_pkg: shared encodings and constants for the race sequencer.
// State codes double as the 2-bit state output seen by HUD/draw logic.
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_FINISHED  = 2'd3
    } state_e;

    localparam int              TIME_W      = 14;
    localparam logic [13:0]     TIME_MAX    = 14'd16383;
    localparam int              TICKS_PER_S = 100;
    localparam int              SUB_W       = 7;

    // Timer increment that sticks at TIME_MAX instead of wrapping.
    function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
        return (v == TIME_MAX) ? v : v + 14'd1;
    endfunction

endpackage

// File: rtl/race_tick_gen.sv
// race_tick_gen: free-running divider producing a 1-cycle tick every
// TICK_DIV cycles. clr restarts the count so the first tick after a clear
// lands exactly TICK_DIV cycles later.
module race_tick_gen #(
    parameter int TICK_DIV = 650000
) (
    input  logic pclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at the last value, restart on clear.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/race_ctrl.sv
// race_ctrl: race sequencer. Runs the start countdown, enables car motion
// during the race, credits laps only when the lap line is crossed with all
// checkpoints passed, and times the race and the current lap.
// Optional: define BEST_LAP_EN to add the best_lap output (fastest lap).
// Handshake note: start and lap_finished are levels; only their rising
// edges are acted upon, and their edge registers reset to 1 so a level
// held high through reset never counts as an edge.
module race_ctrl
    import race_pkg::*;
#(
    parameter int TICK_DIV    = 650000,
    parameter int COUNTDOWN_S = 3,
    parameter int LAPS        = 3
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              start,
    input  logic              lap_finished,
    input  logic              checkpoints_passed,
    output logic [1:0]        state,
    output logic [1:0]        countdown,
    output logic              car_enable,
    output logic [3:0]        lap_count,
    output logic [TIME_W-1:0] race_time,
    output logic [TIME_W-1:0] lap_time,
    output logic              race_done
`ifdef BEST_LAP_EN
    ,
    output logic [TIME_W-1:0] best_lap
`endif
);

    localparam logic [1:0]       CD_INIT  = 2'(COUNTDOWN_S);
    localparam logic [3:0]       LAPS_END = 4'(LAPS);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_S - 1);

    state_e              state_q, state_d;
    logic [1:0]          countdown_q, countdown_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [3:0]          lap_count_q, lap_count_d;
    logic [TIME_W-1:0]   race_time_q, race_time_d;
    logic [TIME_W-1:0]   lap_time_q, lap_time_d;
    logic                race_done_q, race_done_d;
    logic                car_enable_q, car_enable_d;
    logic                start_q, lap_q;
`ifdef BEST_LAP_EN
    logic [TIME_W-1:0]   best_lap_q, best_lap_d;
`endif

    logic       tick;
    logic       start_rise, lap_rise, valid_lap;
    logic       enter_cd, cd_expire;
    logic [3:0] lap_inc;

    assign start_rise = start & ~start_q;
    assign lap_rise   = lap_finished & ~lap_q;
    assign valid_lap  = lap_rise & checkpoints_passed;
    assign lap_inc    = lap_count_q + 4'd1;
    assign cd_expire  = tick && (sub_q == SUB_LAST) && (countdown_q == 2'd1);
    assign enter_cd   = (state_d == ST_COUNTDOWN) && (state_q != ST_COUNTDOWN);

    race_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .pclk (pclk),
        .rst  (rst),
        .clr  (enter_cd),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start edge launches a countdown, countdown expiry starts
    // the race, the final valid lap ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FINISHED: if (start_rise) state_d = ST_COUNTDOWN;
            ST_COUNTDOWN:         if (cd_expire)  state_d = ST_RACE;
            ST_RACE:              if (valid_lap && (lap_inc == LAPS_END)) state_d = ST_FINISHED;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Outputs and timers: initialise on countdown entry, count seconds in
    // countdown, run timers and score laps in the race, hold otherwise.
    always_comb begin
        countdown_d = countdown_q;
        sub_d       = sub_q;
        lap_count_d = lap_count_q;
        race_time_d = race_time_q;
        lap_time_d  = lap_time_q;
`ifdef BEST_LAP_EN
        best_lap_d  = best_lap_q;
`endif
        if (enter_cd) begin
            countdown_d = CD_INIT;
            sub_d       = '0;
            lap_count_d = '0;
            race_time_d = '0;
            lap_time_d  = '0;
`ifdef BEST_LAP_EN
            best_lap_d  = TIME_MAX;
`endif
        end else if (state_q == ST_COUNTDOWN) begin
            if (tick) begin
                if (sub_q == SUB_LAST) begin
                    sub_d       = '0;
                    countdown_d = countdown_q - 2'd1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
        end else if (state_q == ST_RACE) begin
            if (tick) begin
                race_time_d = sat_inc(race_time_q);
                lap_time_d  = sat_inc(lap_time_q);
            end
            // A lap clear wins over a same-cycle tick.
            if (valid_lap) begin
                lap_count_d = lap_inc;
                lap_time_d  = '0;
`ifdef BEST_LAP_EN
                if (lap_time_q < best_lap_q) best_lap_d = lap_time_q;
`endif
            end
        end
        car_enable_d = (state_d == ST_RACE);
        race_done_d  = (state_q == ST_RACE) && (state_d == ST_FINISHED);
    end

    // Datapath and edge-detect registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            countdown_q  <= '0;
            sub_q        <= '0;
            lap_count_q  <= '0;
            race_time_q  <= '0;
            lap_time_q   <= '0;
            race_done_q  <= 1'b0;
            car_enable_q <= 1'b0;
            start_q      <= 1'b1;
            lap_q        <= 1'b1;
`ifdef BEST_LAP_EN
            best_lap_q   <= TIME_MAX;
`endif
        end else begin
            countdown_q  <= countdown_d;
            sub_q        <= sub_d;
            lap_count_q  <= lap_count_d;
            race_time_q  <= race_time_d;
            lap_time_q   <= lap_time_d;
            race_done_q  <= race_done_d;
            car_enable_q <= car_enable_d;
            start_q      <= start;
            lap_q        <= lap_finished;
`ifdef BEST_LAP_EN
            best_lap_q   <= best_lap_d;
`endif
        end
    end

    assign state      = state_q;
    assign countdown  = countdown_q;
    assign car_enable = car_enable_q;
    assign lap_count  = lap_count_q;
    assign race_time  = race_time_q;
    assign lap_time   = lap_time_q;
    assign race_done  = race_done_q;
`ifdef BEST_LAP_EN
    assign best_lap   = best_lap_q;
`endif

endmodule

// File: tb/tb_race_ctrl.sv
// tb_race_ctrl: bench for race_ctrl. Main instance uses TICK_DIV=4,
// COUNTDOWN_S=3, LAPS=2; a second instance (TICK_DIV=1, COUNTDOWN_S=1,
// LAPS=15) exercises timer saturation in a short run.
module tb_race_ctrl;

    localparam int D   = 4;
    localparam int CS  = 3;
    localparam int NL  = 2;
    localparam int MAX = 16383;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst = 1'b1, start = 1'b0, lap_finished = 1'b0, checkpoints_passed = 1'b0;
    logic [1:0]  state, countdown;
    logic        car_enable, race_done;
    logic [3:0]  lap_count;
    logic [13:0] race_time, lap_time;

    logic        rst2 = 1'b1, start2 = 1'b0;
    logic [1:0]  state2, countdown2;
    logic        car_enable2, race_done2;
    logic [3:0]  lap_count2;
    logic [13:0] race_time2, lap_time2;
`ifdef BEST_LAP_EN
    logic [13:0] best_lap, best_lap2;
`endif

    race_ctrl #(.TICK_DIV(D), .COUNTDOWN_S(CS), .LAPS(NL)) dut (
        .pclk(pclk), .rst(rst), .start(start), .lap_finished(lap_finished),
        .checkpoints_passed(checkpoints_passed), .state(state), .countdown(countdown),
        .car_enable(car_enable), .lap_count(lap_count), .race_time(race_time),
        .lap_time(lap_time), .race_done(race_done)
`ifdef BEST_LAP_EN
        , .best_lap(best_lap)
`endif
    );

    race_ctrl #(.TICK_DIV(1), .COUNTDOWN_S(1), .LAPS(15)) dut2 (
        .pclk(pclk), .rst(rst2), .start(start2), .lap_finished(1'b0),
        .checkpoints_passed(1'b0), .state(state2), .countdown(countdown2),
        .car_enable(car_enable2), .lap_count(lap_count2), .race_time(race_time2),
        .lap_time(lap_time2), .race_done(race_done2)
`ifdef BEST_LAP_EN
        , .best_lap(best_lap2)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (edges since countdown entry) -------
    int m_state, m_n, m_rs, m_lap_base, m_laps, m_rt, m_lt, m_best;
    bit m_done, m_sp, m_lp;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit l, input bit c);
        bit sr, lr;
        int t;
        if (r) begin
            m_state = 0; m_sp = 1; m_lp = 1; m_laps = 0; m_rt = 0; m_lt = 0;
            m_done = 0; m_best = MAX; m_n = 0;
            return;
        end
        sr = s & ~m_sp;
        lr = l & ~m_lp;
        m_done = 0;
        case (m_state)
            0, 3: if (sr) begin
                m_state = 1; m_n = 0; m_laps = 0; m_rt = 0; m_lt = 0; m_best = MAX;
            end
            1: begin
                m_n++;
                if (m_n == CS * 100 * D) begin
                    m_state = 2; m_rs = m_n; m_lap_base = 0;
                end
            end
            default: begin
                m_n++;
                t = (m_n - m_rs) / D;
                m_rt = imin(t, MAX);
                if (lr && c) begin
                    m_best = imin(m_best, m_lt);
                    m_lt = 0;
                    m_lap_base = t;
                    m_laps++;
                    if (m_laps == NL) begin
                        m_state = 3; m_done = 1;
                    end
                end else begin
                    m_lt = imin(t - m_lap_base, MAX);
                end
            end
        endcase
        m_sp = s;
        m_lp = l;
    endtask

    task automatic cmp_model();
        check("mdl_state", 32'(state), m_state);
        check("mdl_countdown", 32'(countdown), (m_state == 1) ? CS - (m_n / D) / 100 : 0);
        check("mdl_car_enable", 32'(car_enable), (m_state == 2) ? 1 : 0);
        check("mdl_lap_count", 32'(lap_count), m_laps);
        check("mdl_race_time", 32'(race_time), m_rt);
        check("mdl_lap_time", 32'(lap_time), m_lt);
        check("mdl_race_done", 32'(race_done), 32'(m_done));
`ifdef BEST_LAP_EN
        check("mdl_best_lap", 32'(best_lap), m_best);
`endif
    endtask

    // One clock of the main DUT: drive, step model, sample at negedge.
    task automatic cyc(input bit r, input bit s, input bit l, input bit c);
        rst = r; start = s; lap_finished = l; checkpoints_passed = c;
        @(posedge pclk);
        model_edge(r, s, l, c);
        @(negedge pclk);
        cmp_model();
    endtask

    task automatic run(input int n, input bit s, input bit l, input bit c);
        for (int i = 0; i < n; i++) cyc(1'b0, s, l, c);
    endtask

    task automatic cyc2(input bit r, input bit s);
        rst2 = r; start2 = s;
        @(posedge pclk);
        @(negedge pclk);
    endtask

    // ---------------- vector table: reset / start-edge behaviour ----------
    typedef struct {
        bit r; bit s; bit l; bit c;
        int st; int cd; int car; int laps; int done;
    } vec_t;
    vec_t vecs[14];

    bit rs_s, rs_l, rs_c, rr;

    initial begin
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 1, 3, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 3, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 1, 3, 0, 0, 0};
        vecs[8]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 1, 1, 1, 1, 3, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].r, vecs[i].s, vecs[i].l, vecs[i].c);
            check($sformatf("vec%0d_state", i), 32'(state), vecs[i].st);
            check($sformatf("vec%0d_countdown", i), 32'(countdown), vecs[i].cd);
            check($sformatf("vec%0d_car_enable", i), 32'(car_enable), vecs[i].car);
            check($sformatf("vec%0d_lap_count", i), 32'(lap_count), vecs[i].laps);
            check($sformatf("vec%0d_race_done", i), 32'(race_done), vecs[i].done);
        end

        // ---------------- full race, hand-written expectations -------------
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_state", 32'(state), 0);
        check("rst_race_time", 32'(race_time), 0);
        check("rst_lap_time", 32'(lap_time), 0);
`ifdef BEST_LAP_EN
        check("rst_best_lap", 32'(best_lap), MAX);
`endif
        run(1, 0, 0, 0);
        run(1, 1, 0, 0);                       // entry edge E
        check("cd_entry_state", 32'(state), 1);
        check("cd_entry_value", 32'(countdown), 3);
        run(399, 0, 0, 0);
        check("cd_e399", 32'(countdown), 3);
        run(1, 0, 0, 0);
        check("cd_e400", 32'(countdown), 2);
        run(399, 0, 0, 0);
        check("cd_e799", 32'(countdown), 2);
        run(1, 0, 0, 0);
        check("cd_e800", 32'(countdown), 1);
        run(399, 0, 0, 0);
        check("cd_e1199_state", 32'(state), 1);
        check("cd_e1199_car", 32'(car_enable), 0);
        run(1, 0, 0, 0);                       // race start R = E+1200
        check("race_state", 32'(state), 2);
        check("race_car", 32'(car_enable), 1);
        check("race_countdown", 32'(countdown), 0);
        check("race_time_r0", 32'(race_time), 0);
        run(100, 0, 0, 0);
        check("race_time_r100", 32'(race_time), 25);
        run(10, 0, 1, 0);                      // lap line without checkpoints
        check("false_lap_count", 32'(lap_count), 0);
        check("false_lap_time", 32'(lap_time), 27);
        run(89, 0, 0, 0);
        check("lap_time_r199", 32'(lap_time), 49);
        run(2, 0, 0, 0);
        check("lap_time_r201", 32'(lap_time), 50);
        run(1, 0, 1, 1);                       // first valid lap
        check("lap1_count", 32'(lap_count), 1);
        check("lap1_lap_time", 32'(lap_time), 0);
        check("lap1_race_time", 32'(race_time), 50);
`ifdef BEST_LAP_EN
        check("lap1_best", 32'(best_lap), 50);
`endif
        run(119, 0, 0, 0);
        check("lap2_pre_lap_time", 32'(lap_time), 30);
        run(1, 0, 1, 1);                       // final valid lap
        check("fin_state", 32'(state), 3);
        check("fin_race_done", 32'(race_done), 1);
        check("fin_car", 32'(car_enable), 0);
        check("fin_lap_count", 32'(lap_count), 2);
        check("fin_race_time", 32'(race_time), 80);
        check("fin_lap_time", 32'(lap_time), 0);
`ifdef BEST_LAP_EN
        check("fin_best", 32'(best_lap), 30);
`endif
        run(1, 0, 0, 0);
        check("fin_done_pulse", 32'(race_done), 0);
        run(30, 0, 0, 0);
        check("fin_frozen_time", 32'(race_time), 80);
        check("fin_hold_state", 32'(state), 3);
        run(1, 1, 0, 0);                       // restart
        check("restart_state", 32'(state), 1);
        check("restart_countdown", 32'(countdown), 3);
        check("restart_lap_count", 32'(lap_count), 0);
        check("restart_race_time", 32'(race_time), 0);
`ifdef BEST_LAP_EN
        check("restart_best", 32'(best_lap), MAX);
`endif

        // ---------------- randomized run against the model ----------------
        rs_s = 0; rs_l = 0; rs_c = 0;
        for (int i = 0; i < 15000; i++) begin
            rr = ($urandom_range(0, 4999) == 0);
            if ($urandom_range(0, 249) == 0) rs_s = ~rs_s;
            if ($urandom_range(0, 14) == 0) begin
                rs_l = ~rs_l;
                rs_c = 1'($urandom_range(0, 1));
            end
            cyc(rr, rs_s, rs_l, rs_c);
        end

        // ---------------- saturation on the fast instance -----------------
        cyc2(1, 0);
        check("sat_rst_state", 32'(state2), 0);
        check("sat_rst_race_time", 32'(race_time2), 0);
        cyc2(0, 0);
        cyc2(0, 1);
        check("sat_cd_state", 32'(state2), 1);
        check("sat_cd_value", 32'(countdown2), 1);
        for (int i = 0; i < 99; i++) cyc2(0, 0);
        check("sat_cd_end_state", 32'(state2), 1);
        cyc2(0, 0);
        check("sat_race_state", 32'(state2), 2);
        check("sat_race_car", 32'(car_enable2), 1);
        for (int i = 0; i < 16382; i++) cyc2(0, 0);
        check("sat_race_time_16382", 32'(race_time2), 16382);
        check("sat_lap_time_16382", 32'(lap_time2), 16382);
        cyc2(0, 0);
        check("sat_race_time_max", 32'(race_time2), MAX);
        check("sat_lap_time_max", 32'(lap_time2), MAX);
        for (int i = 0; i < 17; i++) cyc2(0, 0);
        check("sat_race_time_hold", 32'(race_time2), MAX);
        check("sat_lap_time_hold", 32'(lap_time2), MAX);
        check("sat_lap_count", 32'(lap_count2), 0);
        check("sat_state_hold", 32'(state2), 2);
`ifdef BEST_LAP_EN
        check("sat_best", 32'(best_lap2), MAX);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
